// File: rtl/enoc_node_interface.sv
// Network interface between a host node and its router's local port: a TX FIFO that
// stamps packets with {dest, src, seq} and an RX FIFO that splits them back into fields.
// Optional macro ENOC_NI_STATS_EN adds saturating 16-bit TX-pop / RX-push counters.
module enoc_node_interface #(
  parameter int X_NODES       = 4,
  parameter int Y_NODES       = 4,
  parameter int NODE_ID       = 0,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int TX_DEPTH      = 4,
  parameter int RX_DEPTH      = 4,
  localparam int AW = $clog2(X_NODES * Y_NODES),
  localparam int PW = 2 * AW + 8 + PAYLOAD_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PAYLOAD_WIDTH-1:0] i_host_data,
  input  logic [AW-1:0]            i_host_dest,
  input  logic                     i_host_val,
  output logic                     o_host_rdy,
  output logic [PW-1:0]            o_net_data,
  output logic                     o_net_val,
  input  logic                     i_net_en,
  input  logic [PW-1:0]            i_net_data,
  input  logic                     i_net_val,
  output logic                     o_net_en,
  output logic [PAYLOAD_WIDTH-1:0] o_host_data,
  output logic [AW-1:0]            o_host_src,
  output logic [7:0]               o_host_seq,
  output logic                     o_host_val,
  input  logic                     i_host_en
`ifdef ENOC_NI_STATS_EN
  ,
  output logic [15:0]              o_tx_count,
  output logic [15:0]              o_rx_count
`endif
);

  localparam int TPW = $clog2(TX_DEPTH);
  localparam int RPW = $clog2(RX_DEPTH);
  localparam logic [TPW:0] TX_FULL = (TPW + 1)'(TX_DEPTH);
  localparam logic [RPW:0] RX_FULL = (RPW + 1)'(RX_DEPTH);

  logic [PW-1:0]  tx_mem [TX_DEPTH];
  logic [TPW-1:0] tx_wr_reg, tx_rd_reg;
  logic [TPW:0]   tx_cnt_reg;
  logic [7:0]     tx_seq_reg;

  logic [PW-1:0]  rx_mem [RX_DEPTH];
  logic [RPW-1:0] rx_wr_reg, rx_rd_reg;
  logic [RPW:0]   rx_cnt_reg;

  logic          host_push, net_pop, rx_push, host_pop;
  logic [PW-1:0] tx_pkt, rx_head;
  logic          unused_rx_dest;

  // Ready/enable flags come straight from the occupancy registers, never from the
  // opposite side's handshake, so a full FIFO refuses even while it is being popped.
  assign o_host_rdy = (tx_cnt_reg < TX_FULL);
  assign o_net_en   = (rx_cnt_reg < RX_FULL);
  assign o_net_val  = (tx_cnt_reg != '0);
  assign o_host_val = (rx_cnt_reg != '0);

  assign host_push = i_host_val & o_host_rdy;
  assign net_pop   = o_net_val & i_net_en;
  assign rx_push   = i_net_val & o_net_en;
  assign host_pop  = o_host_val & i_host_en;

  assign tx_pkt     = {i_host_dest, AW'(NODE_ID), tx_seq_reg, i_host_data};
  assign o_net_data = tx_mem[tx_rd_reg];

  assign rx_head        = rx_mem[rx_rd_reg];
  assign o_host_data    = rx_head[PAYLOAD_WIDTH-1:0];
  assign o_host_seq     = rx_head[PAYLOAD_WIDTH +: 8];
  assign o_host_src     = rx_head[PAYLOAD_WIDTH + 8 +: AW];
  assign unused_rx_dest = ^rx_head[PW-1 -: AW];

  always_ff @(posedge clk) begin
    if (host_push) tx_mem[tx_wr_reg] <= tx_pkt;
    if (rx_push)   rx_mem[rx_wr_reg] <= i_net_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_reg  <= '0;
      tx_rd_reg  <= '0;
      tx_cnt_reg <= '0;
      tx_seq_reg <= '0;
    end else begin
      if (host_push) begin
        tx_wr_reg  <= tx_wr_reg + 1'b1;
        tx_seq_reg <= tx_seq_reg + 8'd1;
      end
      if (net_pop) tx_rd_reg <= tx_rd_reg + 1'b1;
      case ({host_push, net_pop})
        2'b10:   tx_cnt_reg <= tx_cnt_reg + 1'b1;
        2'b01:   tx_cnt_reg <= tx_cnt_reg - 1'b1;
        default: tx_cnt_reg <= tx_cnt_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_reg  <= '0;
      rx_rd_reg  <= '0;
      rx_cnt_reg <= '0;
    end else begin
      if (rx_push)  rx_wr_reg <= rx_wr_reg + 1'b1;
      if (host_pop) rx_rd_reg <= rx_rd_reg + 1'b1;
      case ({rx_push, host_pop})
        2'b10:   rx_cnt_reg <= rx_cnt_reg + 1'b1;
        2'b01:   rx_cnt_reg <= rx_cnt_reg - 1'b1;
        default: rx_cnt_reg <= rx_cnt_reg;
      endcase
    end
  end

`ifdef ENOC_NI_STATS_EN
  logic [15:0] tx_count_reg, rx_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_count_reg <= '0;
      rx_count_reg <= '0;
    end else begin
      if (net_pop && tx_count_reg != 16'hFFFF) tx_count_reg <= tx_count_reg + 16'd1;
      if (rx_push && rx_count_reg != 16'hFFFF) rx_count_reg <= rx_count_reg + 16'd1;
    end
  end

  assign o_tx_count = tx_count_reg;
  assign o_rx_count = rx_count_reg;
`endif

endmodule

// File: tb/tb_enoc_node_interface.sv
// Bench for enoc_node_interface: queue-based reference model checked every cycle,
// directed handshake/wrap/reset scenarios followed by a randomized traffic phase.
module tb_enoc_node_interface;
  localparam int XN = 4, YN = 4, NID = 5, PWID = 32, TXD = 4, RXD = 4;
  localparam int AW = 4;
  localparam int PW = 2 * AW + 8 + PWID;

  logic            clk = 1'b0;
  logic            reset;
  logic [PWID-1:0] i_host_data;
  logic [AW-1:0]   i_host_dest;
  logic            i_host_val;
  logic            o_host_rdy;
  logic [PW-1:0]   o_net_data;
  logic            o_net_val;
  logic            i_net_en;
  logic [PW-1:0]   i_net_data;
  logic            i_net_val;
  logic            o_net_en;
  logic [PWID-1:0] o_host_data;
  logic [AW-1:0]   o_host_src;
  logic [7:0]      o_host_seq;
  logic            o_host_val;
  logic            i_host_en;
`ifdef ENOC_NI_STATS_EN
  logic [15:0]     o_tx_count, o_rx_count;
`endif

  enoc_node_interface #(
    .X_NODES(XN), .Y_NODES(YN), .NODE_ID(NID), .PAYLOAD_WIDTH(PWID),
    .TX_DEPTH(TXD), .RX_DEPTH(RXD)
  ) dut (
    .clk(clk), .reset(reset),
    .i_host_data(i_host_data), .i_host_dest(i_host_dest), .i_host_val(i_host_val),
    .o_host_rdy(o_host_rdy), .o_net_data(o_net_data), .o_net_val(o_net_val),
    .i_net_en(i_net_en), .i_net_data(i_net_data), .i_net_val(i_net_val),
    .o_net_en(o_net_en), .o_host_data(o_host_data), .o_host_src(o_host_src),
    .o_host_seq(o_host_seq), .o_host_val(o_host_val), .i_host_en(i_host_en)
`ifdef ENOC_NI_STATS_EN
    , .o_tx_count(o_tx_count), .o_rx_count(o_rx_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Reference model: plain queues of whole packets plus a modulo-256 sequence number.
  logic [PW-1:0] txq[$];
  logic [PW-1:0] rxq[$];
  int mseq = 0;
  int tx_stat = 0, rx_stat = 0;
  bit host_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    logic [PW-1:0] h;
    chk("host_rdy", 64'(o_host_rdy), 64'(txq.size() < TXD));
    chk("net_val", 64'(o_net_val), 64'(txq.size() != 0));
    if (txq.size() != 0) chk("net_data", 64'(o_net_data), 64'(txq[0]));
    chk("net_en", 64'(o_net_en), 64'(rxq.size() < RXD));
    chk("host_val", 64'(o_host_val), 64'(rxq.size() != 0));
    if (rxq.size() != 0) begin
      h = rxq[0];
      chk("host_data", 64'(o_host_data), 64'(h[PWID-1:0]));
      chk("host_seq", 64'(o_host_seq), 64'(h[PWID +: 8]));
      chk("host_src", 64'(o_host_src), 64'(h[PWID + 8 +: AW]));
    end
`ifdef ENOC_NI_STATS_EN
    chk("tx_count", 64'(o_tx_count), 64'(tx_stat));
    chk("rx_count", 64'(o_rx_count), 64'(rx_stat));
`endif
  endtask

  // One clock: inputs are already set; advance model across the edge, then compare.
  task automatic tick();
    bit hp, np, rp, hq;
    logic [PW-1:0] newtx, rxin;
    hp = i_host_val && (txq.size() < TXD);
    np = (txq.size() != 0) && i_net_en;
    rp = i_net_val && (rxq.size() < RXD);
    hq = (rxq.size() != 0) && i_host_en;
    newtx = {i_host_dest, AW'(NID), 8'(mseq), i_host_data};
    rxin = i_net_data;
    host_acc = 1'b0;
    @(posedge clk);
    if (reset) begin
      txq.delete();
      rxq.delete();
      mseq = 0;
      tx_stat = 0;
      rx_stat = 0;
    end else begin
      if (np) begin
        $display("net  tx pop   pkt=%h", txq[0]);
        void'(txq.pop_front());
        if (tx_stat < 65535) tx_stat++;
      end
      if (hp) begin
        txq.push_back(newtx);
        mseq = (mseq + 1) % 256;
        host_acc = 1'b1;
      end
      if (hq) begin
        $display("host rx pop   pkt=%h", rxq[0]);
        void'(rxq.pop_front());
      end
      if (rp) begin
        rxq.push_back(rxin);
        if (rx_stat < 65535) rx_stat++;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    i_host_val = 1'b0; i_host_data = '0; i_host_dest = '0;
    i_net_en = 1'b0; i_net_val = 1'b0; i_net_data = '0; i_host_en = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    chk("reset_rdy", 64'(o_host_rdy), 64'd1);
    chk("reset_net_en", 64'(o_net_en), 64'd1);
    chk("reset_net_val", 64'(o_net_val), 64'd0);

    // Single packet with stamped header, visible one edge later, then popped.
    i_host_val = 1'b1; i_host_data = 32'hA5A5A5A5; i_host_dest = 4'd3; i_net_en = 1'b1;
    tick();
    i_host_val = 1'b0;
    chk("single_val", 64'(o_net_val), 64'd1);
    chk("single_data", 64'(o_net_data), 64'({4'd3, 4'd5, 8'h00, 32'hA5A5A5A5}));
    tick();
    chk("single_popped", 64'(o_net_val), 64'd0);

    // TX backpressure: 5 writes into depth 4, then release.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      i_host_val = 1'b1; i_host_data = 32'(i); i_host_dest = AW'(i);
      tick();
      if (i == 3) chk("txfull_rdy_low", 64'(o_host_rdy), 64'd0);
    end
    i_net_en = 1'b1;
    for (int k = 0; k < 10 && i_host_val; k++) begin
      tick();
      if (host_acc) i_host_val = 1'b0;
    end
    chk("txfull_fifth_accepted", 64'(mseq), 64'd5);
    for (int k = 0; k < 6; k++) tick();

    // Sequence wrap over 257 packets.
    do_reset();
    i_net_en = 1'b1; i_host_val = 1'b1;
    for (int i = 0; i < 257; i++) begin
      i_host_data = $urandom; i_host_dest = AW'($urandom);
      tick();
      if (i == 255) chk("seq_255", 64'(o_net_data[PWID +: 8]), 64'd255);
      if (i == 256) chk("seq_wrap_0", 64'(o_net_data[PWID +: 8]), 64'd0);
    end
    i_host_val = 1'b0;
    tick();

    // RX backpressure: router offers 5, node not accepting.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      i_net_val = 1'b1; i_net_data = PW'({$urandom, $urandom});
      tick();
      if (i == 3) chk("rxfull_en_low", 64'(o_net_en), 64'd0);
    end
    i_net_val = 1'b0; i_host_en = 1'b1;
    tick();
    chk("rxfull_en_recovers", 64'(o_net_en), 64'd1);
    for (int k = 0; k < 4; k++) tick();
    chk("rx_drained", 64'(o_host_val), 64'd0);

    // RX simultaneous push/pop at occupancy 2.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      i_net_val = 1'b1; i_net_data = PW'({$urandom, $urandom});
      tick();
    end
    i_host_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_net_data = PW'({$urandom, $urandom});
      tick();
      chk("rx_steady_occ", 64'(rxq.size() == 2 && o_net_en && o_host_val), 64'd1);
    end
    idle();
    tick();

    // Reset discards 3 queued packets in each direction.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      i_host_val = 1'b1; i_host_data = $urandom; i_host_dest = AW'($urandom);
      i_net_val = 1'b1; i_net_data = PW'({$urandom, $urandom});
      tick();
    end
    chk("prereset_tx_val", 64'(o_net_val), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    chk("postreset_net_val", 64'(o_net_val), 64'd0);
    chk("postreset_host_val", 64'(o_host_val), 64'd0);
    i_host_val = 1'b1; i_host_data = 32'h1234_5678; i_host_dest = 4'd9;
    tick();
    i_host_val = 1'b0;
    chk("postreset_seq0", 64'(o_net_data[PWID +: 8]), 64'd0);
    i_net_en = 1'b1;
    tick();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      i_host_val = ($urandom_range(0, 3) != 0);
      i_host_data = $urandom;
      i_host_dest = AW'($urandom);
      i_net_en = ($urandom_range(0, 2) != 0);
      i_net_val = ($urandom_range(0, 1) != 0);
      i_net_data = PW'({$urandom, $urandom});
      i_host_en = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/enoc_node_interface.md
ENOC_NODE_INTERFACE -- requirements
Module: enoc_node_interface

Interface
REQ-001 Parameter X_NODES, default 4, number of node columns.
REQ-002 Parameter Y_NODES, default 4, number of node rows.
REQ-003 Parameter NODE_ID, default 0, this node's address (0..X_NODES*Y_NODES-1).
REQ-004 Parameter PAYLOAD_WIDTH, default 32, host payload bits.
REQ-005 Parameters TX_DEPTH and RX_DEPTH, default 4 each, FIFO entries, power of two, >=2.
REQ-006 Derived: AW = clog2(X_NODES*Y_NODES); PW = 2*AW+8+PAYLOAD_WIDTH; packet layout MSB..LSB = {dest[AW], src[AW], seq[8], payload}.
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 i_host_data  in  PAYLOAD_WIDTH  TX payload from node.
REQ-010 i_host_dest  in  AW  TX destination address.
REQ-011 i_host_val  in  1  TX request valid.
REQ-012 o_host_rdy  out  1  TX FIFO can accept this cycle.
REQ-013 o_net_data  out  PW  packet to router local input.
REQ-014 o_net_val  out  1  o_net_data valid.
REQ-015 i_net_en  in  1  router local input can accept.
REQ-016 i_net_data  in  PW  packet from router local output.
REQ-017 i_net_val  in  1  i_net_data valid.
REQ-018 o_net_en  out  1  block can accept from router.
REQ-019 o_host_data / o_host_src / o_host_seq  out  PAYLOAD_WIDTH / AW / 8  received payload, source, sequence.
REQ-020 o_host_val  out  1  received packet valid; i_host_en  in  1  node accepts.

Function
REQ-021 Transfer on any valid/enable pair SHALL occur on a rising edge where val=1 and en=1; val SHALL NOT depend combinationally on en.
REQ-022 o_host_rdy SHALL equal (TX occupancy < TX_DEPTH), from registered state only.
REQ-023 On host TX transfer the block SHALL push {i_host_dest, NODE_ID, tx_seq, i_host_data} and increment 8-bit tx_seq, wrapping 255->0.
REQ-024 o_net_val SHALL equal TX FIFO non-empty; o_net_data SHALL be FIFO head; head pops on o_net_val&i_net_en.
REQ-025 TX latency: host transfer at edge N -> o_net_val=1 after edge N (no combinational fall-through).
REQ-026 o_net_en SHALL equal (RX occupancy < RX_DEPTH), registered state only; full -> 0 even if host pops same cycle.
REQ-027 RX push on i_net_val&o_net_en; o_host_val = RX non-empty; o_host_* = head fields; pop on o_host_val&i_host_en.
REQ-028 Simultaneous push and pop on either FIFO SHALL leave occupancy unchanged and preserve order.
REQ-029 Packets with dest != NODE_ID SHALL still be delivered unchanged (no filtering).
REQ-030 Pointers SHALL wrap modulo depth; occupancy counter AW-independent, clog2(depth)+1 bits.

Reset
REQ-031 While reset=1: FIFOs empty, tx_seq=0, o_net_val=0, o_host_val=0, o_host_rdy=1, o_net_en=1 after first reset edge; counters 0.
REQ-032 Reset asserted mid-transfer SHALL discard all queued packets; no transfer completes on the reset edge.

Configuration
REQ-033 Macro ENOC_NI_STATS_EN defined: ports o_tx_count and o_rx_count (out, 16 bits) SHALL count network-side TX pops and RX pushes, saturating at 65535, reset to 0.
REQ-034 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-035 NODE_ID=5, host sends payload 0xA5A5A5A5 dest 3, i_net_en=1 -> one cycle later o_net_val=1, data {3,5,0x00,0xA5A5A5A5}, popped next edge.
REQ-036 i_net_en=0, 5 host writes with TX_DEPTH=4 -> o_host_rdy=0 after 4th, 5th held; release en -> 4 packets seq 0..3 in order, then 5th seq 4.
REQ-037 257 TX packets -> seq wraps 255 then 0 on packet 257.
REQ-038 i_host_en=0, router offers 5 packets -> o_net_en=0 after 4; raise i_host_en -> 4 delivered in order, o_net_en=1 next cycle.
REQ-039 Simultaneous RX push/pop with occupancy 2 for 10 cycles -> occupancy stays 2, no loss or reorder.
REQ-040 reset pulse with 3 queued in each FIFO -> next cycle o_net_val=0, o_host_val=0, tx_seq restarts 0; with ENOC_NI_STATS_EN counters read 0.
